change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The parameters SHALL be:
- TOTAL_BITS, 31, width of all amount signals.
- COIN0_VAL, 100, value of coin type 0.
- COIN1_VAL, 500, value of coin type 1.
- COIN2_VAL, 1000, value of coin type 2.

REQ-002 The ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-high reset (asserted when 1).
- return_req  in  1  one-cycle request to dispense return_amount.
- return_amount  in  TOTAL_BITS  amount to return; sampled only when the request is accepted.
- coin_valid  out  1  a coin is offered on coin_type.
- coin_type  out  2  denomination offered (0/1/2).
- coin_ready  in  1  coin mechanism accepts the offered coin.
- busy  out  1  dispense in progress (state is not IDLE).
- done  out  1  one-cycle pulse when dispensing is complete.
- residue  out  TOTAL_BITS  undispensable remainder; valid while done=1.

Function
REQ-003 The FSM SHALL have four states: IDLE, SELECT, EMIT and FIN.
REQ-004 In IDLE, return_req=1 SHALL latch return_amount into the internal register rem and move to SELECT, or to FIN if return_amount < COIN0_VAL.
REQ-005 The block SHALL ignore return_req while busy=1; rem is not modified.
REQ-006 SELECT SHALL choose the largest coin with value <= rem (priority 2, then 1, then 0), register it into coin_type, and move to EMIT.
REQ-007 In EMIT, coin_valid SHALL be 1, and coin_type SHALL be stable until the cycle where coin_valid and coin_ready are both 1.
REQ-008 On that handshake, rem SHALL become rem minus the coin value. The next state SHALL be FIN if the new rem < COIN0_VAL, else SELECT.
REQ-009 coin_valid SHALL be 0 in IDLE, SELECT and FIN. coin_ready SHALL be ignored outside EMIT.
REQ-010 Throughput: with coin_ready held at 1, one coin SHALL be emitted every 2 cycles. The first coin_valid SHALL appear 2 cycles after the accepted request.
REQ-011 FIN SHALL assert done=1 for exactly one cycle with residue=rem, then return to IDLE. residue SHALL be 0 outside FIN.
REQ-012 Subtraction SHALL never underflow, because a coin is selected only if its value <= rem.
REQ-013 return_amount=0 SHALL produce no coins and a done pulse one cycle after the request, with residue 0.
REQ-014 A request accepted in the same cycle that FIN returns to IDLE is not possible; a request is accepted only when the current state is IDLE.

Reset
REQ-015 Asserting reset_n SHALL immediately force the following, regardless of clk: state IDLE, rem 0, coin_valid 0, coin_type 0, busy 0, done 0, residue 0.
REQ-016 A reset during EMIT SHALL abort the transaction. The partially dispensed coins are not reported, and no done pulse is generated.
REQ-017 The first request SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-018 When CHANGE_DISPENSER_COUNT_EN is defined, the block SHALL add outputs cnt0, cnt1 and cnt2 (8 bits each). Each counts the coins of that type handshaken in the current transaction. The counts are cleared on request acceptance, hold their values through FIN until the next accepted request, are cleared by reset, and saturate at 255.
REQ-019 When CHANGE_DISPENSER_COUNT_EN is undefined, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-020 return_amount=1700, coin_ready=1 -> coin_type sequence 2,1,0,0 on consecutive handshakes; then done with residue=0; busy deasserts the cycle after done.
REQ-021 return_amount=1750 -> coins 2,1,0,0; done with residue=50.
REQ-022 return_amount=500, coin_ready held 0 for 5 cycles -> coin_valid=1 and coin_type=1 stable for all 5 cycles; a single coin is emitted when coin_ready rises; then done with residue=0.
REQ-023 return_amount=60 -> no coin_valid; done one cycle after the request with residue=60. A second return_req pulsed during a 1000 dispense -> ignored, exactly one coin emitted.
REQ-024 reset_n asserted mid-EMIT of a 1500 dispense -> coin_valid and busy drop in the same cycle without a clock edge; no done pulse; a new 100 request afterwards -> one type-0 coin and done.
REQ-025 With CHANGE_DISPENSER_COUNT_EN defined, 2600 -> cnt2=2, cnt1=1, cnt0=1 at done.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a requested return amount into coins of three
// denominations (largest first) and offers them one at a time over a
// valid/ready handshake to the coin mechanism.
// Anything below the smallest coin value is reported as residue when done.
// Optional build macro: CHANGE_DISPENSER_COUNT_EN adds per-denomination
// coin counters cnt0/cnt1/cnt2 for the current transaction.
// Note: reset_n is active-high despite its name (asserted when 1).

module change_dispenser #(
  parameter int TOTAL_BITS = 31,
  parameter int COIN0_VAL  = 100,
  parameter int COIN1_VAL  = 500,
  parameter int COIN2_VAL  = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  return_req,
  input  logic [TOTAL_BITS-1:0] return_amount,
  output logic                  coin_valid,
  output logic [1:0]            coin_type,
  input  logic                  coin_ready,
  output logic                  busy,
  output logic                  done,
  output logic [TOTAL_BITS-1:0] residue
`ifdef CHANGE_DISPENSER_COUNT_EN
  ,
  output logic [7:0]            cnt0,
  output logic [7:0]            cnt1,
  output logic [7:0]            cnt2
`endif
);

  localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VAL);
  localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VAL);
  localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VAL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EMIT   = 2'd2,
    FIN    = 2'd3
  } State;

  State                  r_state;
  logic [TOTAL_BITS-1:0] r_rem;

  logic [TOTAL_BITS-1:0] w_coinVal;
  logic [TOTAL_BITS-1:0] w_remAfter;
  logic [1:0]            w_selType;
  logic                  w_accept;
  logic                  w_handshake;

  assign w_accept    = (r_state == IDLE) && return_req;
  assign w_handshake = (r_state == EMIT) && coin_ready;
  // A coin is only selected when its value fits in r_rem, so this never wraps.
  assign w_remAfter  = r_rem - w_coinVal;

  // Value of the coin currently being offered, used to shrink r_rem on handshake.
  always_comb begin
    w_coinVal = C0;
    case (coin_type)
      2'd2:    w_coinVal = C2;
      2'd1:    w_coinVal = C1;
      default: w_coinVal = C0;
    endcase
  end

  // Greedy pick: the largest denomination that still fits in the remainder.
  always_comb begin
    w_selType = 2'd0;
    if (r_rem >= C2) begin
      w_selType = 2'd2;
    end else if (r_rem >= C1) begin
      w_selType = 2'd1;
    end
  end

  // Dispense FSM; every output is registered and driven from this block only.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      coin_valid <= 1'b0;
      coin_type  <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      residue    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done    <= 1'b0;
          residue <= '0;
          if (return_req) begin
            r_rem <= return_amount;
            busy  <= 1'b1;
            if (return_amount < C0) begin
              r_state <= FIN;
              done    <= 1'b1;
              residue <= return_amount;
            end else begin
              r_state <= SELECT;
            end
          end
        end
        SELECT: begin
          coin_type  <= w_selType;
          coin_valid <= 1'b1;
          r_state    <= EMIT;
        end
        EMIT: begin
          if (coin_ready) begin
            coin_valid <= 1'b0;
            r_rem      <= w_remAfter;
            if (w_remAfter < C0) begin
              r_state <= FIN;
              done    <= 1'b1;
              residue <= w_remAfter;
            end else begin
              r_state <= SELECT;
            end
          end
        end
        FIN: begin
          done    <= 1'b0;
          residue <= '0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          coin_valid <= 1'b0;
          done       <= 1'b0;
          residue    <= '0;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

`ifdef CHANGE_DISPENSER_COUNT_EN
  // Per-denomination coin counts for the current transaction, saturating at 255.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
      cnt2 <= 8'd0;
    end else if (w_accept) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
      cnt2 <= 8'd0;
    end else if (w_handshake) begin
      case (coin_type)
        2'd2:    if (cnt2 != 8'hFF) cnt2 <= cnt2 + 8'd1;
        2'd1:    if (cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
        default: if (cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed bench for change_dispenser with a coin and
// residue scoreboard filled when a request is driven and drained by a monitor
// whenever the DUT hands over a coin or pulses done.

module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        return_req;
  logic [30:0] return_amount;
  logic        coin_valid;
  logic [1:0]  coin_type;
  logic        coin_ready;
  logic        busy;
  logic        done;
  logic [30:0] residue;
`ifdef CHANGE_DISPENSER_COUNT_EN
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;
  logic [7:0]  cnt2;
`endif

  int checkCount  = 0;
  int passCount   = 0;
  int cycleCount  = 0;
  int lastHsCycle = -1;
  bit checkThroughput = 1'b0;
  int coinQ[$];
  int resQ[$];

  change_dispenser dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .return_req   (return_req),
    .return_amount(return_amount),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .coin_ready   (coin_ready),
    .busy         (busy),
    .done         (done),
    .residue      (residue)
`ifdef CHANGE_DISPENSER_COUNT_EN
    ,
    .cnt0         (cnt0),
    .cnt1         (cnt1),
    .cnt2         (cnt2)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure the spacing between coin handshakes.
  always @(posedge clk) cycleCount++;

  // One comparison: counts it, and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Drive one request and push the greedy breakdown into the scoreboard.
  task automatic applyStimulus(input int amount);
    int rem;
    rem = amount;
    return_req    = 1'b1;
    return_amount = 31'(amount);
    while (rem >= 100) begin
      if (rem >= 1000) begin
        coinQ.push_back(2);
        rem -= 1000;
      end else if (rem >= 500) begin
        coinQ.push_back(1);
        rem -= 500;
      end else begin
        coinQ.push_back(0);
        rem -= 100;
      end
    end
    resQ.push_back(rem);
    lastHsCycle = -1;
    @(posedge clk);
    #1 return_req = 1'b0;
  endtask

  // Wait (bounded) for done, then check the cycle after it and the scoreboard.
  task automatic waitDone(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    checkOutput({tag, "_doneSeen"}, 64'(done), 64'd1);
    checkOutput({tag, "_coinsLeft"}, 64'(coinQ.size()), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_doneOnePulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_busyAfterDone"}, 64'(busy), 64'd0);
    checkOutput({tag, "_residueLeft"}, 64'(resQ.size()), 64'd0);
  endtask

  // Monitor: drains the scoreboard on handshakes and done pulses.
  always @(negedge clk) begin
    if (coin_valid === 1'b1 && coin_ready === 1'b1) begin
      checkOutput("coinExpected", 64'(coinQ.size() > 0), 64'd1);
      if (coinQ.size() > 0) checkOutput("coinType", 64'(coin_type), 64'(coinQ.pop_front()));
      if (checkThroughput && lastHsCycle >= 0)
        checkOutput("coinSpacing", 64'(cycleCount - lastHsCycle), 64'd2);
      lastHsCycle = cycleCount;
    end
    if (done === 1'b1) begin
      checkOutput("doneExpected", 64'(resQ.size() > 0), 64'd1);
      if (resQ.size() > 0) checkOutput("residue", 64'(residue), 64'(resQ.pop_front()));
    end else begin
      checkOutput("residueZero", 64'(residue), 64'd0);
    end
  end

  initial begin
    reset_n       = 1'b1;
    return_req    = 1'b0;
    return_amount = '0;
    coin_ready    = 1'b1;

    // Reset values appear before any clock edge.
    #2;
    checkOutput("rstValid", 64'(coin_valid), 64'd0);
    checkOutput("rstType", 64'(coin_type), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstResidue", 64'(residue), 64'd0);

    // 1700 right after reset release: 2,1,0,0 back to back, residue 0.
    @(negedge clk);
    reset_n = 1'b0;
    checkThroughput = 1'b1;
    applyStimulus(1700);
    @(negedge clk);
    checkOutput("selectNoValid", 64'(coin_valid), 64'd0);
    checkOutput("busyAfterAccept", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("firstCoinLatency", 64'(coin_valid), 64'd1);
    waitDone("amt1700");

    // 1750: same coins, residue 50.
    @(posedge clk); #1;
    applyStimulus(1750);
    waitDone("amt1750");

    // 500 with coin_ready low for 5 cycles: offer stays stable.
    @(posedge clk); #1;
    checkThroughput = 1'b0;
    coin_ready = 1'b0;
    applyStimulus(500);
    @(negedge clk);
    checkOutput("holdSelectNoValid", 64'(coin_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("holdValid", 64'(coin_valid), 64'd1);
      checkOutput("holdType", 64'(coin_type), 64'd1);
    end
    @(posedge clk); #1;
    coin_ready = 1'b1;
    waitDone("amt500");

    // 60: no coins, done on the next cycle with residue 60.
    @(posedge clk); #1;
    checkThroughput = 1'b1;
    applyStimulus(60);
    @(negedge clk);
    checkOutput("smallDoneNow", 64'(done), 64'd1);
    checkOutput("smallNoValid", 64'(coin_valid), 64'd0);
    @(negedge clk);
    checkOutput("smallBusyDrop", 64'(busy), 64'd0);
    checkOutput("smallLeft", 64'(resQ.size()), 64'd0);

    // 0: done one cycle after the request, residue 0.
    @(posedge clk); #1;
    applyStimulus(0);
    @(negedge clk);
    checkOutput("zeroDoneNow", 64'(done), 64'd1);
    @(negedge clk);
    checkOutput("zeroBusyDrop", 64'(busy), 64'd0);

    // 1000 with a second request while busy: ignored, exactly one coin.
    @(posedge clk); #1;
    applyStimulus(1000);
    return_req    = 1'b1;
    return_amount = 31'd500;
    @(posedge clk);
    #1 return_req = 1'b0;
    waitDone("busyIgnore");

    // Reset in the middle of EMIT for 1500: drops at once, no done.
    @(posedge clk); #1;
    checkThroughput = 1'b0;
    coin_ready = 1'b0;
    applyStimulus(1500);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abortInEmit", 64'(coin_valid), 64'd1);
    #2 reset_n = 1'b1;
    #1;
    checkOutput("abortValidDrop", 64'(coin_valid), 64'd0);
    checkOutput("abortBusyDrop", 64'(busy), 64'd0);
    coinQ.delete();
    resQ.delete();
    repeat (2) begin
      @(negedge clk);
      checkOutput("abortNoDone", 64'(done), 64'd0);
    end
    reset_n    = 1'b0;
    coin_ready = 1'b1;
    applyStimulus(100);
    waitDone("afterAbort100");

`ifdef CHANGE_DISPENSER_COUNT_EN
    // 2600: counters report 2/1/1 and hold after done.
    @(posedge clk); #1;
    checkThroughput = 1'b1;
    applyStimulus(2600);
    waitDone("amt2600");
    checkOutput("cnt2", 64'(cnt2), 64'd2);
    checkOutput("cnt1", 64'(cnt1), 64'd1);
    checkOutput("cnt0", 64'(cnt0), 64'd1);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
